// File: rtl/switch_debounce_event.sv
// Four-pin active-low switch conditioner: two-flop sync, per-pin debounce,
// and a single-entry valid/ready change-event slot with overrun flag.
module switch_debounce_event #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned CNT_W           = 17
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  input  logic       switch4,
  output logic [3:0] sw_state,
  output logic       event_valid,
  output logic [3:0] event_data,
  output logic       event_overrun,
  input  logic       event_ready
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       s;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       done;
  logic [3:0]       state_nxt;
  logic             chg;
  logic             xfer;

  assign raw = {switch1, switch2, switch3, switch4};
  assign s   = ~sync2;

  // Sync flops reset to the released level so no false press appears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_comb begin
    done = '0;
    for (int i = 0; i < 4; i++) begin
      done[i] = (s[i] != sw_state[i]) &&
                (cnt[i] == CNT_LAST);
    end
  end

  assign state_nxt = sw_state ^ done;
  assign chg       = |done;
  assign xfer      = event_valid & event_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s[i] == sw_state[i] || done[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_state <= '0;
    end else begin
      sw_state <= state_nxt;
    end
  end

  // A change landing on an accept edge refills the slot without loss.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_valid   <= 1'b0;
      event_data    <= '0;
      event_overrun <= 1'b0;
    end else begin
      if (chg) begin
        event_valid   <= 1'b1;
        event_data    <= state_nxt;
        event_overrun <= event_valid & ~event_ready
                       | event_overrun & ~xfer;
      end else if (xfer) begin
        event_valid   <= 1'b0;
        event_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/switch_debounce_event.md
Name: switch_debounce_event

Overview:
- Conditions the four raw, active-low push-switch pins for the UART switch-reporting path.
- Synchronises each pin, debounces it with a per-switch stability counter, and presents an active-high, debounced 4-bit switch state.
- Publishes every debounced change as a valid/ready event, which the downstream UART send controller consumes and transmits.
- Sits directly upstream of the send controller, on the same system clock.

Parameters:
- DEBOUNCE_CYCLES, 120000: consecutive clk cycles a synchronised pin must differ from the debounced state before the change is accepted. Default is 10 ms at 12 MHz. Legal range 2..2^24.
- CNT_W, 17: debounce counter width. Must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk, input, 1: system clock; all logic is rising-edge.
- reset_n, input, 1: asynchronous, active-low reset.
- switch1, input, 1: raw switch pin, active-low (pressed = 0), asynchronous to clk.
- switch2, input, 1: as switch1.
- switch3, input, 1: as switch1.
- switch4, input, 1: as switch1.
- sw_state, output, 4: debounced state, active-high (1 = pressed). Bit 3 = switch1, bit 0 = switch4.
- event_valid, output, 1: a change event is pending.
- event_data, output, 4: sw_state value captured at the most recent change. Same bit order as sw_state.
- event_overrun, output, 1: at least one earlier pending event was overwritten before it was accepted.
- event_ready, input, 1: consumer accepts the event.

Behaviour:
- Reset (asserted asynchronously, released synchronously by design intent):
  - Both synchroniser stages = 1 (released).
  - sw_state = 0, event_data = 0, event_valid = 0, event_overrun = 0.
  - All counters = 0.
- Synchroniser:
  - Two flip-flops per pin.
  - The inverted output of the second stage is the "sampled" level s[i] (1 = pressed).
- Debounce, per bit i, independent:
  - If s[i] == sw_state[i]: counter[i] <= 0.
  - Else if counter[i] == DEBOUNCE_CYCLES-1: sw_state[i] <= s[i]; counter[i] <= 0.
  - Else: counter[i] <= counter[i] + 1.
  - Any cycle where s[i] matches sw_state[i] restarts the count. A glitch shorter than DEBOUNCE_CYCLES cycles never reaches sw_state.
  - Latency: sw_state[i] changes exactly DEBOUNCE_CYCLES+1 rising edges after the first edge that samples the new pin level, provided the pin then stays stable.
- Change detect:
  - chg = 1 on any edge where at least one sw_state bit toggles. Several bits toggling on the same edge form one event.
  - On that edge: event_data <= new sw_state value (the same value sw_state takes), and event_valid <= 1.
- Handshake: a transfer occurs on an edge where event_valid && event_ready. Per edge:
  - Transfer without chg: event_valid <= 0; event_overrun <= 0; event_data holds.
  - Transfer with chg: event_valid stays 1; event_data <= new value; event_overrun <= 0. The accepted event was the old one, so no loss.
  - event_valid && !event_ready with chg: event_data overwritten; event_overrun <= 1 (sticky until the next transfer).
  - !event_valid with chg: event_valid <= 1; event_overrun holds 0.
  - event_ready while !event_valid: ignored.
  - event_data and event_overrun are stable while event_valid && !event_ready, except on an overwrite.
- A change back to an earlier value is still an event. No suppression of equal-to-last-accepted data.
- Reset mid-debounce or mid-handshake: everything returns to reset values immediately. A pin held pressed through reset is reported as a fresh event DEBOUNCE_CYCLES+2 edges after reset release.
- Counter arithmetic is unsigned CNT_W bits and never wraps, because it clears at DEBOUNCE_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset:
  - Stimulus: all pins 1; hold reset_n=0, then release.
  - Required: sw_state=0, event_valid=0, event_overrun=0, and none change for 20 cycles.
- Clean press:
  - Stimulus: switch1 driven 0 at edge k and held.
  - Required: sw_state=4'b1000 and event_valid=1 with event_data=4'b1000 at edge k+5.
  - Then, with event_ready=1 for one cycle: event_valid=0 on the next edge.
- Bounce rejection:
  - Stimulus: switch3 toggles 0,1,0,1 at 3-cycle intervals, then returns to 1.
  - Required: sw_state stays 0000 and event_valid never asserts.
- Simultaneous change:
  - Stimulus: switch2 and switch4 driven 0 on the same edge.
  - Required: a single event with event_data=4'b0101.
- Overrun:
  - Stimulus: event_ready=0; press switch1 and let it debounce; then press switch2 and let it debounce.
  - Required: event_valid=1, event_data=4'b1100, event_overrun=1.
  - Then, with event_ready=1 for one cycle: event_valid=0 and event_overrun=0.
- Accept coinciding with change, then reset mid-debounce:
  - Stimulus: assert event_ready on exactly the edge of a new debounced change.
  - Required: event_valid stays 1, event_data = new value, event_overrun=0.
  - Stimulus: pulse reset_n low while a counter is at 2.
  - Required: all outputs 0 immediately.
